// File: rtl/seq_access_scheduler.sv
// Serialises UPD / RX / TX accesses to the per-host sequence-counter table.
// One operation in flight; every output is registered.
`ifndef HOST_ADDR_WIDTH
`define HOST_ADDR_WIDTH 4
`endif

module seq_access_scheduler #(
  parameter int unsigned HOST_ADDR = `HOST_ADDR_WIDTH,
  parameter int unsigned MAX_SIZE  = 80,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned TOUT_W    = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  // session-manager overwrite
  input  logic                 upd_req_i,
  input  logic [HOST_ADDR-1:0] upd_addr_i,
  input  logic [MAX_SIZE-1:0]  upd_val_i,
  output logic                 upd_done_o,
  // receive-path lookup
  input  logic                 rx_req_i,
  input  logic [HOST_ADDR-1:0] rx_addr_i,
  output logic                 rx_done_o,
  output logic [MAX_SIZE-1:0]  rx_seq_o,
  // transmit-path allocation
  input  logic                 tx_req_i,
  input  logic [HOST_ADDR-1:0] tx_addr_i,
  input  logic                 tx_ignore_i,
  output logic                 tx_done_o,
  output logic                 tx_valid_o,
  output logic                 tx_timeout_o,
  output logic [MAX_SIZE-1:0]  tx_seq_o,
  output logic [3:0]           tx_width_o,
  output logic                 busy_o,
  // sequence_generator control
  output logic                 gen_update_o,
  output logic [HOST_ADDR-1:0] gen_upd_loc_o,
  output logic [MAX_SIZE-1:0]  gen_new_seq_o,
  output logic                 gen_create_o,
  output logic                 gen_ignore_o,
  output logic [HOST_ADDR-1:0] gen_tx_addr_o,
  output logic                 gen_rx_o,
  output logic [HOST_ADDR-1:0] gen_rx_addr_o,
  input  logic [MAX_SIZE-1:0]  gen_expected_i,
  input  logic [MAX_SIZE-1:0]  gen_outgoing_i,
  input  logic [3:0]           gen_width_i,
  input  logic                 gen_valid_i
);

  localparam logic [TOUT_W-1:0] ToutLast = TOUT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StUpd,
    StRxIssue,
    StRxWait,
    StTxIssue,
    StTxWait,
    StDone
  } state_e;

  state_e              state_q;
  logic                rr_tx_q;  // 1: TX has priority over RX at the next contested grant
  logic [TOUT_W-1:0]   tout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      rr_tx_q       <= 1'b0;
      tout_q        <= '0;
      upd_done_o    <= 1'b0;
      rx_done_o     <= 1'b0;
      rx_seq_o      <= '0;
      tx_done_o     <= 1'b0;
      tx_valid_o    <= 1'b0;
      tx_timeout_o  <= 1'b0;
      tx_seq_o      <= '0;
      tx_width_o    <= '0;
      busy_o        <= 1'b0;
      gen_update_o  <= 1'b0;
      gen_upd_loc_o <= '0;
      gen_new_seq_o <= '0;
      gen_create_o  <= 1'b0;
      gen_ignore_o  <= 1'b0;
      gen_tx_addr_o <= '0;
      gen_rx_o      <= 1'b0;
      gen_rx_addr_o <= '0;
    end else begin
      // Pulses and per-pulse payloads default low; only the owning state raises them.
      upd_done_o    <= 1'b0;
      rx_done_o     <= 1'b0;
      tx_done_o     <= 1'b0;
      tx_valid_o    <= 1'b0;
      tx_timeout_o  <= 1'b0;
      gen_update_o  <= 1'b0;
      gen_upd_loc_o <= '0;
      gen_new_seq_o <= '0;
      gen_create_o  <= 1'b0;
      gen_ignore_o  <= 1'b0;
      gen_rx_o      <= 1'b0;
      gen_rx_addr_o <= '0;

      unique case (state_q)
        StIdle: begin
          if (upd_req_i) begin
            state_q       <= StUpd;
            busy_o        <= 1'b1;
            gen_update_o  <= 1'b1;
            gen_upd_loc_o <= upd_addr_i;
            gen_new_seq_o <= upd_val_i;
          end else if (rx_req_i && (!tx_req_i || !rr_tx_q)) begin
            state_q       <= StRxIssue;
            busy_o        <= 1'b1;
            rr_tx_q       <= 1'b1;
            gen_rx_o      <= 1'b1;
            gen_rx_addr_o <= rx_addr_i;
          end else if (tx_req_i) begin
            state_q       <= StTxIssue;
            busy_o        <= 1'b1;
            rr_tx_q       <= 1'b0;
            gen_create_o  <= 1'b1;
            gen_ignore_o  <= tx_ignore_i;
            gen_tx_addr_o <= tx_addr_i;
          end
        end
        StUpd: begin
          state_q    <= StDone;
          upd_done_o <= 1'b1;
        end
        StRxIssue: state_q <= StRxWait;
        StRxWait: begin
          // The generator presents its registered lookup result in this cycle.
          state_q   <= StDone;
          rx_seq_o  <= gen_expected_i;
          rx_done_o <= 1'b1;
        end
        StTxIssue: begin
          // gen_ignore_o still carries the latched ignore flag during issue.
          if (gen_ignore_o) begin
            state_q   <= StDone;
            tx_done_o <= 1'b1;
          end else begin
            state_q <= StTxWait;
            tout_q  <= '0;
          end
        end
        StTxWait: begin
          if (gen_valid_i) begin
            state_q    <= StDone;
            tx_seq_o   <= gen_outgoing_i;
            tx_width_o <= gen_width_i;
            tx_done_o  <= 1'b1;
            tx_valid_o <= 1'b1;
          end else if (tout_q == ToutLast) begin
            state_q      <= StDone;
            tx_seq_o     <= '0;
            tx_done_o    <= 1'b1;
            tx_timeout_o <= 1'b1;
          end else begin
            tout_q <= tout_q + TOUT_W'(1);
          end
        end
        StDone: begin
          state_q       <= StIdle;
          busy_o        <= 1'b0;
          gen_tx_addr_o <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_access_scheduler.sv
// Randomised self-checking bench for seq_access_scheduler against a behavioural
// model of the arbitration order, handshake latencies and ASCII sequence values.
module tb_seq_access_scheduler;
  localparam int unsigned HA = 4;
  localparam int unsigned MS = 80;
  localparam int unsigned TO = 64;
  localparam int unsigned TW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          upd_req_i = 1'b0;
  logic [HA-1:0] upd_addr_i = '0;
  logic [MS-1:0] upd_val_i = '0;
  logic          upd_done_o;
  logic          rx_req_i = 1'b0;
  logic [HA-1:0] rx_addr_i = '0;
  logic          rx_done_o;
  logic [MS-1:0] rx_seq_o;
  logic          tx_req_i = 1'b0;
  logic [HA-1:0] tx_addr_i = '0;
  logic          tx_ignore_i = 1'b0;
  logic          tx_done_o, tx_valid_o, tx_timeout_o;
  logic [MS-1:0] tx_seq_o;
  logic [3:0]    tx_width_o;
  logic          busy_o;
  logic          gen_update_o;
  logic [HA-1:0] gen_upd_loc_o;
  logic [MS-1:0] gen_new_seq_o;
  logic          gen_create_o, gen_ignore_o;
  logic [HA-1:0] gen_tx_addr_o;
  logic          gen_rx_o;
  logic [HA-1:0] gen_rx_addr_o;
  logic [MS-1:0] gen_expected_i = '0;
  logic [MS-1:0] gen_outgoing_i = '0;
  logic [3:0]    gen_width_i = '0;
  logic          gen_valid_i = 1'b0;

  seq_access_scheduler #(
    .HOST_ADDR(HA), .MAX_SIZE(MS), .TIMEOUT(TO), .TOUT_W(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .upd_req_i(upd_req_i), .upd_addr_i(upd_addr_i), .upd_val_i(upd_val_i),
    .upd_done_o(upd_done_o),
    .rx_req_i(rx_req_i), .rx_addr_i(rx_addr_i), .rx_done_o(rx_done_o), .rx_seq_o(rx_seq_o),
    .tx_req_i(tx_req_i), .tx_addr_i(tx_addr_i), .tx_ignore_i(tx_ignore_i),
    .tx_done_o(tx_done_o), .tx_valid_o(tx_valid_o), .tx_timeout_o(tx_timeout_o),
    .tx_seq_o(tx_seq_o), .tx_width_o(tx_width_o), .busy_o(busy_o),
    .gen_update_o(gen_update_o), .gen_upd_loc_o(gen_upd_loc_o), .gen_new_seq_o(gen_new_seq_o),
    .gen_create_o(gen_create_o), .gen_ignore_o(gen_ignore_o), .gen_tx_addr_o(gen_tx_addr_o),
    .gen_rx_o(gen_rx_o), .gen_rx_addr_o(gen_rx_addr_o),
    .gen_expected_i(gen_expected_i), .gen_outgoing_i(gen_outgoing_i),
    .gen_width_i(gen_width_i), .gen_valid_i(gen_valid_i)
  );

  always #5 clk = ~clk;

  logic outs_nz;
  assign outs_nz = |{upd_done_o, rx_done_o, rx_seq_o, tx_done_o, tx_valid_o, tx_timeout_o,
                     tx_seq_o, tx_width_o, busy_o, gen_update_o, gen_upd_loc_o, gen_new_seq_o,
                     gen_create_o, gen_ignore_o, gen_tx_addr_o, gen_rx_o, gen_rx_addr_o};

  int n_cmp = 0;
  int n_err = 0;
  // Model state: round-robin preference and last captured TX result.
  bit            ptr_tx = 1'b0;
  logic [MS-1:0] last_seq = '0;
  logic [3:0]    last_w = '0;

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [MS-1:0] rnd_wide();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[MS-1:0];
  endfunction

  // Decimal ASCII, least-significant character in bits [7:0].
  function automatic void to_ascii(input int unsigned n, output logic [MS-1:0] s,
                                   output logic [3:0] w);
    int unsigned v;
    int k;
    v = n;
    k = 0;
    s = '0;
    do begin
      s[k*8 +: 8] = 8'h30 + 8'(v % 10);
      v = v / 10;
      k++;
    end while (v != 0);
    w = 4'(k);
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    ptr_tx = 1'b0;
    last_seq = '0;
    last_w = '0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (outs_nz !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs got_nonzero=%b exp=0", outs_nz);
    end
    do_reset();
    step();
    n_cmp++;
    if (outs_nz !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset got_nonzero=%b exp=0", outs_nz);
    end
  endtask

  task automatic test_upd(input logic [HA-1:0] a, input logic [MS-1:0] v);
    upd_addr_i = a; upd_val_i = v; upd_req_i = 1'b1;
    step();
    n_cmp++;
    if ({gen_update_o, gen_upd_loc_o, gen_new_seq_o, busy_o, upd_done_o} !== {1'b1, a, v, 2'b10})
    begin
      n_err++; $display("FAIL upd_issue got=%0b/%h/%h exp=1/%h/%h",
                        gen_update_o, gen_upd_loc_o, gen_new_seq_o, a, v);
    end
    step();
    n_cmp++;
    if ({upd_done_o, gen_update_o, busy_o} !== 3'b101) begin
      n_err++; $display("FAIL upd_done got=%b exp=101", {upd_done_o, gen_update_o, busy_o});
    end
    upd_req_i = 1'b0;
    upd_val_i = rnd_wide();
    step();
    n_cmp++;
    if ({upd_done_o, busy_o} !== 2'b00) begin
      n_err++; $display("FAIL upd_idle got=%b exp=00", {upd_done_o, busy_o});
    end
  endtask

  task automatic test_rx(input logic [HA-1:0] a, input logic [MS-1:0] v);
    gen_expected_i = rnd_wide();
    rx_addr_i = a; rx_req_i = 1'b1;
    ptr_tx = 1'b1;
    step();
    n_cmp++;
    if ({gen_rx_o, gen_rx_addr_o} !== {1'b1, a}) begin
      n_err++; $display("FAIL rx_issue got=%b/%h exp=1/%h", gen_rx_o, gen_rx_addr_o, a);
    end
    step();
    gen_expected_i = v;  // generator's registered result, present only during the wait cycle
    n_cmp++;
    if ({gen_rx_o, rx_done_o} !== 2'b00) begin
      n_err++; $display("FAIL rx_wait got=%b exp=00", {gen_rx_o, rx_done_o});
    end
    step();
    gen_expected_i = rnd_wide();
    n_cmp++;
    if ({rx_done_o, rx_seq_o} !== {1'b1, v}) begin
      n_err++; $display("FAIL rx_done got=%b/%h exp=1/%h", rx_done_o, rx_seq_o, v);
    end
    rx_req_i = 1'b0;
    step();
    step();
    n_cmp++;
    if ({rx_done_o, busy_o, rx_seq_o} !== {2'b00, v}) begin
      n_err++; $display("FAIL rx_hold got=%b%b/%h exp=00/%h", rx_done_o, busy_o, rx_seq_o, v);
    end
  endtask

  // d: cycles from the issue cycle to the cycle gen_valid_i is high (>= 2).
  task automatic test_tx(input logic [HA-1:0] a, input int unsigned n, input int d);
    logic [MS-1:0] s;
    logic [3:0] w;
    to_ascii(n, s, w);
    tx_addr_i = a; tx_ignore_i = 1'b0; tx_req_i = 1'b1;
    ptr_tx = 1'b0;
    step();
    n_cmp++;
    if ({gen_create_o, gen_ignore_o, gen_tx_addr_o} !== {2'b10, a}) begin
      n_err++; $display("FAIL tx_issue got=%b%b/%h exp=10/%h",
                        gen_create_o, gen_ignore_o, gen_tx_addr_o, a);
    end
    // A valid during issue must be ignored.
    gen_valid_i = 1'b1; gen_outgoing_i = rnd_wide(); gen_width_i = 4'($urandom);
    step();
    gen_valid_i = 1'b0;
    repeat (d - 1) begin
      n_cmp++;
      if ({tx_done_o, gen_create_o, gen_tx_addr_o} !== {2'b00, a}) begin
        n_err++; $display("FAIL tx_wait got=%b%b/%h exp=00/%h",
                          tx_done_o, gen_create_o, gen_tx_addr_o, a);
      end
      step();
    end
    gen_valid_i = 1'b1; gen_outgoing_i = s; gen_width_i = w;
    step();
    gen_valid_i = 1'b0; gen_outgoing_i = rnd_wide();
    n_cmp++;
    if ({tx_done_o, tx_valid_o, tx_timeout_o, tx_width_o, tx_seq_o, gen_tx_addr_o} !==
        {3'b110, w, s, a}) begin
      n_err++; $display("FAIL tx_done got=%b%b%b w=%0d seq=%h addr=%h exp=110 w=%0d seq=%h addr=%h",
                        tx_done_o, tx_valid_o, tx_timeout_o, tx_width_o, tx_seq_o,
                        gen_tx_addr_o, w, s, a);
    end
    last_seq = s; last_w = w;
    tx_req_i = 1'b0;
    step();
    n_cmp++;
    if ({tx_done_o, busy_o, tx_seq_o} !== {2'b00, s}) begin
      n_err++; $display("FAIL tx_hold got=%b%b/%h exp=00/%h", tx_done_o, busy_o, tx_seq_o, s);
    end
  endtask

  task automatic test_tx_ignore(input logic [HA-1:0] a);
    tx_addr_i = a; tx_ignore_i = 1'b1; tx_req_i = 1'b1;
    ptr_tx = 1'b0;
    step();
    n_cmp++;
    if ({gen_create_o, gen_ignore_o, gen_tx_addr_o} !== {2'b11, a}) begin
      n_err++; $display("FAIL txign_issue got=%b%b/%h exp=11/%h",
                        gen_create_o, gen_ignore_o, gen_tx_addr_o, a);
    end
    step();
    n_cmp++;
    if ({tx_done_o, tx_valid_o, tx_timeout_o, tx_seq_o, tx_width_o} !==
        {3'b100, last_seq, last_w}) begin
      n_err++; $display("FAIL txign_done got=%b%b%b/%h/%0d exp=100/%h/%0d", tx_done_o,
                        tx_valid_o, tx_timeout_o, tx_seq_o, tx_width_o, last_seq, last_w);
    end
    tx_req_i = 1'b0; tx_ignore_i = 1'b0;
    step();
  endtask

  task automatic test_timeout(input logic [HA-1:0] a);
    int done_at;
    tx_addr_i = a; tx_ignore_i = 1'b0; tx_req_i = 1'b1; gen_valid_i = 1'b0;
    ptr_tx = 1'b0;
    done_at = -1;
    step();
    for (int c = 2; c < 2 + int'(TO) + 20; c++) begin
      step();
      if (tx_done_o === 1'b1) begin
        done_at = c;
        break;
      end
    end
    n_cmp++;
    if (done_at != 2 + int'(TO)) begin
      n_err++; $display("FAIL tout_cycle got=%0d exp=%0d", done_at, 2 + int'(TO));
    end
    n_cmp++;
    if ({tx_valid_o, tx_timeout_o, tx_seq_o, tx_width_o} !== {2'b01, {MS{1'b0}}, last_w}) begin
      n_err++; $display("FAIL tout_flags got=%b%b/%h/%0d exp=01/0/%0d",
                        tx_valid_o, tx_timeout_o, tx_seq_o, tx_width_o, last_w);
    end
    last_seq = '0;
    tx_req_i = 1'b0;
    step();
  endtask

  task automatic test_reset_midflight();
    logic [MS-1:0] s;
    logic [3:0] w;
    logic [HA-1:0] a;
    int done_seen;
    a = HA'($urandom);
    tx_addr_i = a; tx_ignore_i = 1'b0; tx_req_i = 1'b1; gen_valid_i = 1'b0;
    repeat (5) step();
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (outs_nz !== 1'b0) begin
      n_err++; $display("FAIL rst_async got_nonzero=%b exp=0", outs_nz);
    end
    done_seen = 0;
    repeat (3) begin
      step();
      if (tx_done_o !== 1'b0) done_seen++;
    end
    n_cmp++;
    if (done_seen != 0) begin
      n_err++; $display("FAIL rst_no_done got=%0d exp=0", done_seen);
    end
    rst = 1'b1;
    ptr_tx = 1'b0; last_seq = '0; last_w = '0;
    step();
    n_cmp++;
    if ({gen_create_o, gen_tx_addr_o} !== {1'b1, a}) begin
      n_err++; $display("FAIL rst_recreate got=%b/%h exp=1/%h", gen_create_o, gen_tx_addr_o, a);
    end
    to_ascii($urandom_range(0, 99999), s, w);
    step();
    gen_valid_i = 1'b1; gen_outgoing_i = s; gen_width_i = w;
    step();
    gen_valid_i = 1'b0;
    n_cmp++;
    if ({tx_done_o, tx_valid_o, tx_seq_o} !== {2'b11, s}) begin
      n_err++; $display("FAIL rst_complete got=%b%b/%h exp=11/%h",
                        tx_done_o, tx_valid_o, tx_seq_o, s);
    end
    last_seq = s; last_w = w;
    tx_req_i = 1'b0;
    step();
  endtask

  // Done order is encoded as base-4 digits: 1=UPD, 2=RX, 3=TX.
  task automatic test_arbitration();
    bit u, r, t, again, pu, pr, pt, ag;
    int exp_code, got_code, multi;
    logic [2:0] pick;
    do_reset();
    for (int round = 0; round < 12; round++) begin
      if (round == 0) begin
        u = 1; r = 1; t = 1; again = 1;
      end else begin
        pick = 3'($urandom_range(1, 7));
        {u, r, t} = pick;
        again = 1'($urandom);
      end
      pu = u; pr = r; pt = t; ag = again && r;
      exp_code = 0;
      while (pu || pr || pt) begin
        if (pu) begin
          exp_code = exp_code * 4 + 1; pu = 0;
        end else if (pr && (!pt || !ptr_tx)) begin
          exp_code = exp_code * 4 + 2; ptr_tx = 1;
          if (ag) ag = 0; else pr = 0;
        end else begin
          exp_code = exp_code * 4 + 3; ptr_tx = 0; pt = 0;
        end
      end
      upd_addr_i = HA'($urandom); rx_addr_i = HA'($urandom); tx_addr_i = HA'($urandom);
      upd_val_i = rnd_wide(); tx_ignore_i = 1'b1;
      upd_req_i = u; rx_req_i = r; tx_req_i = t; ag = again && r;
      got_code = 0; multi = 0;
      for (int c = 0; c < 60 && (upd_req_i || rx_req_i || tx_req_i); c++) begin
        step();
        if (int'(upd_done_o) + int'(rx_done_o) + int'(tx_done_o) > 1) multi++;
        if (upd_done_o === 1'b1) begin
          got_code = got_code * 4 + 1; upd_req_i = 1'b0;
        end
        if (rx_done_o === 1'b1) begin
          got_code = got_code * 4 + 2;
          if (ag) ag = 0; else rx_req_i = 1'b0;
        end
        if (tx_done_o === 1'b1) begin
          got_code = got_code * 4 + 3; tx_req_i = 1'b0;
        end
      end
      n_cmp++;
      if (got_code != exp_code || multi != 0) begin
        n_err++; $display("FAIL arb_order round=%0d got=%0h overlap=%0d exp=%0h overlap=0",
                          round, got_code, multi, exp_code);
      end
      upd_req_i = 1'b0; rx_req_i = 1'b0; tx_req_i = 1'b0;
      step();
    end
    tx_ignore_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_upd(4'd3, 80'd500);
    repeat (3) test_upd(HA'($urandom), rnd_wide());
    test_rx(4'd5, 80'd124);
    repeat (3) test_rx(HA'($urandom), rnd_wide());
    test_tx(4'd2, 125, 3);
    repeat (4) test_tx(HA'($urandom), $urandom, $urandom_range(2, 10));
    test_tx_ignore(HA'($urandom));
    test_timeout(HA'($urandom));
    test_tx_ignore(HA'($urandom));
    test_reset_midflight();
    test_arbitration();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired exp=finish_before_limit");
    $fatal(1, "watchdog");
  end

endmodule
